// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply-divide unit: one-cycle multiply, restoring
// radix-2^DIV_UNROLL divider, result written back from the DONE state.
module muldiv_unit #(
    parameter int XLEN       = 32,
    parameter int DIV_UNROLL = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            inst_v_i,
    input  logic [31:0]     inst_i,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic            accept,
    output logic            busy,
    output logic [4:0]      rd,
    output logic            rd_v,
    output logic [XLEN-1:0] rd_data
);
    localparam int ITER  = XLEN / DIV_UNROLL;
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t state;

    logic [1:0]       op_q;
    logic [XLEN-1:0]  a_reg, b_reg, rem_reg;
    logic             sgn_a, sgn_b, neg_q, neg_r;
    logic [CNT_W-1:0] cnt;

    logic            m_op, div_in, sdiv_in, rs1_neg, rs2_neg;
    logic            div_zero, div_ovf, special;
    logic [2:0]      f3_in;
    logic [XLEN-1:0] abs1, abs2, special_res;
    logic            unused_fields;

    assign m_op    = (inst_i[6:0] == 7'b0110011) && (inst_i[31:25] == 7'b0000001);
    assign f3_in   = inst_i[14:12];
    assign div_in  = f3_in[2];
    assign sdiv_in = div_in & ~f3_in[0];
    assign rs1_neg = sdiv_in & rs1_data[XLEN-1];
    assign rs2_neg = sdiv_in & rs2_data[XLEN-1];
    assign abs1    = rs1_neg ? -rs1_data : rs1_data;
    assign abs2    = rs2_neg ? -rs2_data : rs2_data;

    // Divide-by-zero and signed overflow bypass the iteration entirely.
    assign div_zero    = (rs2_data == '0);
    assign div_ovf     = sdiv_in && (rs1_data == MOST_NEG) && (rs2_data == '1);
    assign special     = div_in & (div_zero | div_ovf);
    assign special_res = div_zero ? (f3_in[1] ? rs1_data : '1)
                                  : (f3_in[1] ? '0 : MOST_NEG);

    // Register-number fields are decoded upstream; only folded here.
    assign unused_fields = ^inst_i[24:15];

    assign accept = inst_v_i & m_op & ~flush & ((state == IDLE) | (state == DONE));
    assign busy   = (state == MUL) | (state == DIV);
    assign rd_v   = (state == DONE) & (rd != 5'd0);

    logic [2*XLEN-1:0] mul_a, mul_b, mul_p;
    logic [XLEN-1:0]   mul_res;

    always_comb begin
        mul_a   = {{XLEN{sgn_a & a_reg[XLEN-1]}}, a_reg};
        mul_b   = {{XLEN{sgn_b & b_reg[XLEN-1]}}, b_reg};
        mul_p   = mul_a * mul_b;
        mul_res = (op_q == 2'b00) ? mul_p[XLEN-1:0] : mul_p[2*XLEN-1:XLEN];
    end

    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] q_n, r_n, div_res;

    // NOTE: every variable gets a value before the loop so no latch is inferred.
    always_comb begin
        q_n     = a_reg;
        r_n     = rem_reg;
        shifted = '0;
        for (int i = 0; i < DIV_UNROLL; i++) begin
            shifted = {r_n, q_n[XLEN-1]};
            q_n     = {q_n[XLEN-2:0], 1'b0};
            if (shifted >= {1'b0, b_reg}) begin
                shifted = shifted - {1'b0, b_reg};
                q_n[0]  = 1'b1;
            end
            r_n = shifted[XLEN-1:0];
        end
        div_res = op_q[1] ? (neg_r ? -r_n : r_n) : (neg_q ? -q_n : q_n);
    end

    // NOTE: non-blocking assignments for all state so every register samples
    // pre-edge values. Datapath registers are not reset: they are always
    // loaded on accept before they are read.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            rd      <= '0;
            rd_data <= '0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                MUL: begin
                    rd_data <= mul_res;
                    state   <= DONE;
                end
                DIV: begin
                    a_reg   <= q_n;
                    rem_reg <= r_n;
                    if (cnt == '0) begin
                        rd_data <= div_res;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: ;
            endcase

            if (accept) begin
                op_q <= f3_in[1:0];
                rd   <= inst_i[11:7];
                if (div_in) begin
                    a_reg   <= abs1;
                    b_reg   <= abs2;
                    rem_reg <= '0;
                    neg_q   <= rs1_neg ^ rs2_neg;
                    neg_r   <= rs1_neg;
                    cnt     <= CNT_W'(ITER - 1);
                    if (special) begin
                        rd_data <= special_res;
                        state   <= DONE;
                    end else begin
                        state <= DIV;
                    end
                end else begin
                    a_reg <= rs1_data;
                    b_reg <= rs2_data;
                    sgn_a <= (f3_in[1:0] == 2'b01) | (f3_in[1:0] == 2'b10);
                    sgn_b <= (f3_in[1:0] == 2'b01);
                    state <= MUL;
                end
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: two instances (DIV_UNROLL 1 and 4)
// checked against an arithmetic reference model of the RV32M operations.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inst_v = 1'b0;
    logic        flush = 1'b0;
    logic        sel = 1'b0;
    logic [31:0] inst = '0, rs1 = '0, rs2 = '0;

    logic        acc1, busy1, rdv1, acc4, busy4, rdv4;
    logic [4:0]  rd1, rd4;
    logic [31:0] data1, data4;
    logic        o_acc, o_busy, o_rdv;
    logic [4:0]  o_rd;
    logic [31:0] o_data;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32), .DIV_UNROLL(1)) u_dut1 (
        .clk(clk), .reset(reset), .inst_v_i(inst_v & ~sel), .inst_i(inst),
        .rs1_data(rs1), .rs2_data(rs2), .flush(flush), .accept(acc1),
        .busy(busy1), .rd(rd1), .rd_v(rdv1), .rd_data(data1));

    muldiv_unit #(.XLEN(32), .DIV_UNROLL(4)) u_dut4 (
        .clk(clk), .reset(reset), .inst_v_i(inst_v & sel), .inst_i(inst),
        .rs1_data(rs1), .rs2_data(rs2), .flush(flush), .accept(acc4),
        .busy(busy4), .rd(rd4), .rd_v(rdv4), .rd_data(data4));

    assign o_acc  = sel ? acc4  : acc1;
    assign o_busy = sel ? busy4 : busy1;
    assign o_rdv  = sel ? rdv4  : rdv1;
    assign o_rd   = sel ? rd4   : rd1;
    assign o_data = sel ? data4 : data1;

    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f3)
            3'd0: begin p = ua * ub; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                else begin p = sa / sb; r = p[31:0]; end
            end
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
                else begin p = sa % sb; r = p[31:0]; end
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int exp_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (!f3[2]) return 2;
        if (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
        return sel ? 9 : 33;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    task automatic drive_inst(input logic [2:0] f3, input logic [4:0] rdn, input logic [31:0] a, input logic [31:0] b);
        inst   = {7'b0000001, 5'd2, 5'd1, f3, rdn, 7'b0110011};
        rs1    = a;
        rs2    = b;
        inst_v = 1'b1;
    endtask

    // Waits for accept; returns just after the edge that starts cycle T+1.
    task automatic wait_accept(output bit ok);
        ok = 0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            if (o_acc === 1'b1) ok = 1;
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL accept_timeout: accept=%b, required 1 within 100 cycles", o_acc);
        end
        @(posedge clk); #1;
        inst_v = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [4:0] rdn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp;
        int lat;
        bit ok;
        exp = ref_model(f3, a, b);
        lat = exp_latency(f3, a, b);
        @(posedge clk); #1;
        drive_inst(f3, rdn, a, b);
        wait_accept(ok);
        if (!ok) return;
        for (int n = 1; n <= lat + 2; n++) begin
            @(negedge clk);
            tests++;
            if (o_busy !== 1'(n < lat)) begin
                fails++;
                $display("FAIL busy f3=%0d T+%0d: got %b, required %b", f3, n, o_busy, n < lat);
            end
            if (n == lat) begin
                tests += 2;
                if (o_rdv !== 1'(rdn != 0)) begin
                    fails++;
                    $display("FAIL rd_v f3=%0d rd=%0d T+%0d: got %b, required %b", f3, rdn, n, o_rdv, rdn != 0);
                end
                if (o_data !== exp) begin
                    fails++;
                    $display("FAIL rd_data f3=%0d a=%h b=%h: got %h, required %h", f3, a, b, o_data, exp);
                end
                if (rdn != 0) begin
                    tests++;
                    if (o_rd !== rdn) begin
                        fails++;
                        $display("FAIL rd f3=%0d: got %0d, required %0d", f3, o_rd, rdn);
                    end
                end
            end else begin
                tests++;
                if (o_rdv !== 1'b0) begin
                    fails++;
                    $display("FAIL rd_v_stray f3=%0d T+%0d: got %b, required 0", f3, n, o_rdv);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        tests += 2;
        if ({busy1, rdv1, rd1, data1, acc1} !== '0) begin
            fails++;
            $display("FAIL reset_dut1: busy=%b rd_v=%b rd=%0d rd_data=%h accept=%b, required all 0", busy1, rdv1, rd1, data1, acc1);
        end
        if ({busy4, rdv4, rd4, data4, acc4} !== '0) begin
            fails++;
            $display("FAIL reset_dut4: busy=%b rd_v=%b rd=%0d rd_data=%h accept=%b, required all 0", busy4, rdv4, rd4, data4, acc4);
        end
        // A base-ISA ADD must be ignored.
        @(posedge clk); #1;
        inst = {7'b0000000, 5'd2, 5'd1, 3'd0, 5'd3, 7'b0110011};
        inst_v = 1'b1;
        @(negedge clk);
        tests++;
        if (o_acc !== 1'b0) begin
            fails++;
            $display("FAIL non_m_accept: got %b, required 0", o_acc);
        end
        @(posedge clk); #1 inst_v = 1'b0;
        @(negedge clk);
        tests++;
        if (o_busy !== 1'b0 || o_rdv !== 1'b0) begin
            fails++;
            $display("FAIL non_m_state: busy=%b rd_v=%b, required 0 0", o_busy, o_rdv);
        end
    endtask

    task automatic test_mul();
        sel = 1'b0;
        run_op(3'd0, 5'd1, 32'd7, 32'hFFFF_FFFD);
        run_op(3'd1, 5'd2, 32'h8000_0000, 32'h8000_0000);
        run_op(3'd2, 5'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(3'd3, 5'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    endtask

    task automatic test_div();
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            run_op(3'd5, 5'd5, 32'd100, 32'd7);
            run_op(3'd7, 5'd6, 32'd100, 32'd7);
            run_op(3'd4, 5'd7, 32'hFFFF_FFF9, 32'd2);
            run_op(3'd6, 5'd8, 32'hFFFF_FFF9, 32'd2);
        end
    endtask

    task automatic test_special();
        sel = 1'b0;
        run_op(3'd4, 5'd9,  32'd1234, 32'd0);
        run_op(3'd7, 5'd10, 32'd5, 32'd0);
        run_op(3'd4, 5'd11, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(3'd6, 5'd12, 32'h8000_0000, 32'hFFFF_FFFF);
    endtask

    task automatic test_rd_x0();
        sel = 1'b0;
        run_op(3'd0, 5'd0, 32'd6, 32'd9);
        run_op(3'd5, 5'd0, 32'd77, 32'd5);
    endtask

    task automatic test_flush();
        bit ok;
        sel = 1'b0;
        @(posedge clk); #1;
        drive_inst(3'd5, 5'd5, 32'd1000, 32'd3);
        wait_accept(ok);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        tests++;
        if (o_busy !== 1'b1 || o_rdv !== 1'b0) begin
            fails++;
            $display("FAIL flush_t10: busy=%b rd_v=%b, required 1 0", o_busy, o_rdv);
        end
        @(posedge clk); #1 flush = 1'b0;
        drive_inst(3'd0, 5'd6, 32'd9, 32'd11);
        @(negedge clk);
        tests++;
        if (o_busy !== 1'b0 || o_acc !== 1'b1) begin
            fails++;
            $display("FAIL flush_t11: busy=%b accept=%b, required 0 1", o_busy, o_acc);
        end
        @(posedge clk); #1 inst_v = 1'b0;
        for (int n = 12; n <= 45; n++) begin
            @(negedge clk);
            tests++;
            if (n == 13) begin
                if (o_rdv !== 1'b1 || o_rd !== 5'd6 || o_data !== 32'd99) begin
                    fails++;
                    $display("FAIL flush_mul_wb: rd_v=%b rd=%0d rd_data=%h, required 1 6 00000063", o_rdv, o_rd, o_data);
                end
            end else if (o_rdv !== 1'b0) begin
                fails++;
                $display("FAIL flush_stray_wb T+%0d: rd_v=%b rd=%0d, required rd_v 0", n, o_rdv, o_rd);
            end
        end
        // Flush together with a valid M-op must block the accept.
        @(posedge clk); #1;
        flush = 1'b1;
        drive_inst(3'd0, 5'd7, 32'd2, 32'd2);
        @(negedge clk);
        tests++;
        if (o_acc !== 1'b0) begin
            fails++;
            $display("FAIL flush_blocks_accept: got %b, required 0", o_acc);
        end
        @(posedge clk); #1 flush = 1'b0; inst_v = 1'b0;
        @(negedge clk);
        tests++;
        if (o_busy !== 1'b0) begin
            fails++;
            $display("FAIL flush_blocks_busy: got %b, required 0", o_busy);
        end
        // Flush in DONE leaves that cycle's write-back in place.
        @(posedge clk); #1;
        drive_inst(3'd0, 5'd7, 32'd3, 32'd4);
        wait_accept(ok);
        @(posedge clk); #1 flush = 1'b1;
        @(negedge clk);
        tests++;
        if (o_rdv !== 1'b1 || o_data !== 32'd12) begin
            fails++;
            $display("FAIL flush_done_wb: rd_v=%b rd_data=%h, required 1 0000000c", o_rdv, o_data);
        end
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        tests++;
        if (o_rdv !== 1'b0 || o_busy !== 1'b0) begin
            fails++;
            $display("FAIL flush_done_after: rd_v=%b busy=%b, required 0 0", o_rdv, o_busy);
        end
    endtask

    task automatic test_back_to_back(input bit s);
        bit ok;
        int lat;
        sel = s;
        lat = s ? 9 : 33;
        @(posedge clk); #1;
        drive_inst(3'd4, 5'd3, 32'hFFFF_FF9C, 32'd7);
        wait_accept(ok);
        drive_inst(3'd0, 5'd4, 32'hFFFF_FFFB, 32'd6);
        for (int n = 1; n <= lat; n++) begin
            @(negedge clk);
            tests++;
            if (n < lat) begin
                if (o_acc !== 1'b0) begin
                    fails++;
                    $display("FAIL b2b_held T+%0d: accept=%b, required 0", n, o_acc);
                end
            end else if (o_acc !== 1'b1 || o_rdv !== 1'b1 || o_rd !== 5'd3 || o_data !== 32'hFFFF_FFF2) begin
                fails++;
                $display("FAIL b2b_div_wb: accept=%b rd_v=%b rd=%0d rd_data=%h, required 1 1 3 fffffff2", o_acc, o_rdv, o_rd, o_data);
            end
        end
        @(posedge clk); #1 inst_v = 1'b0;
        @(negedge clk);
        tests++;
        if (o_busy !== 1'b1 || o_rdv !== 1'b0) begin
            fails++;
            $display("FAIL b2b_mul_busy: busy=%b rd_v=%b, required 1 0", o_busy, o_rdv);
        end
        @(negedge clk);
        tests++;
        if (o_rdv !== 1'b1 || o_rd !== 5'd4 || o_data !== 32'hFFFF_FFE2) begin
            fails++;
            $display("FAIL b2b_mul_wb: rd_v=%b rd=%0d rd_data=%h, required 1 4 ffffffe2", o_rdv, o_rd, o_data);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            sel = 1'($urandom_range(0, 1));
            run_op(3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), pick_operand(), pick_operand());
        end
    endtask

    task automatic test_reset_mid_op();
        bit ok;
        bit seen;
        sel = 1'b0;
        run_op(3'd0, 5'd2, 32'd5, 32'd5);
        @(posedge clk); #1;
        drive_inst(3'd5, 5'd9, 32'd12345, 32'd7);
        wait_accept(ok);
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        tests++;
        if (o_busy !== 1'b0 || o_data !== 32'd0 || o_rd !== 5'd0) begin
            fails++;
            $display("FAIL reset_mid_op: busy=%b rd_data=%h rd=%0d, required 0 0 0", o_busy, o_data, o_rd);
        end
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (o_rdv === 1'b1) seen = 1;
        end
        tests++;
        if (seen) begin
            fails++;
            $display("FAIL reset_mid_op_wb: rd_v rose after reset, required never");
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_rd_x0();
        test_flush();
        test_back_to_back(1'b0);
        test_back_to_back(1'b1);
        test_random();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
